// File: rtl/mixer_fader_pkg.sv
// mixer_fader_pkg: register map, FSM encoding and field widths shared by the fader blocks
package mixer_fader_pkg;
    localparam int VOL_W = 4;
    localparam int IMM_BIT = 8;
    localparam logic [3:0] REG_CH = 4'd0;
    localparam logic [3:0] REG_PERIOD = 4'd8;
    localparam logic [3:0] REG_STATUS = 4'd9;
    typedef enum logic [1:0] {IDLE, SCAN, WRITE, NEXT} state_t;
endpackage

// File: rtl/mixer_fader_tick.sv
// fader_tick: step-period counter with reload, pause on zero period and a saturating pending flag
module fader_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] period,
    input  logic             reload,
    input  logic             clr,
    output logic             tick_pend
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic pend_q, pend_d, wrap;
    always_comb begin
        wrap = (period != '0) && !reload && (cnt_q == period - 1'b1);
        cnt_d = (reload || period == '0 || wrap) ? '0 : cnt_q + 1'b1;
        pend_d = wrap | (pend_q & ~clr);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pend_q <= pend_d;
        end
    end
    assign tick_pend = pend_q;
endmodule

// File: rtl/mixer_fader.sv
// mixer_fader: per-channel volume ramping toward CPU targets, pushing changed volumes to the mixer bus
module mixer_fader
    import mixer_fader_pkg::*;
#(
    parameter int          N_CH = 8,
    parameter int          DIV_W = 16,
    parameter logic [31:0] MIX_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    output logic        ready,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        settled
);
    state_t state_q, state_d;
    logic [2:0] idx_q, idx_d, ch;
    logic step_en_q, step_en_d, ready_q, ready_d, m_valid_q, m_valid_d;
    logic [VOL_W-1:0] target_q [N_CH], target_d [N_CH], cur_q [N_CH], cur_d [N_CH];
    logic [VOL_W-1:0] c, t, nv;
    logic [N_CH-1:0] dirty_q, dirty_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [31:0] rdata_q, rdata_d, m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic [3:0] m_wstrb_q, m_wstrb_d;
    logic access, wr, ch_ok, step, need, settled_w, tick_pend, tick_clr, tick_reload;
    logic unused_bits;
    assign unused_bits = ^{wstrb[3:1], addr[31:6], addr[1:0], wdata};

    fader_tick #(.DIV_W(DIV_W)) u_tick (
        .clk(clk), .reset(reset), .period(period_q), .reload(tick_reload),
        .clr(tick_clr), .tick_pend(tick_pend)
    );

    always_comb begin
        access = valid & ~ready_q;
        wr = access & wstrb[0];
        ch = addr[4:2];
        ch_ok = ((addr[5:2] & 4'b1000) == REG_CH) && ({29'b0, ch} < 32'(N_CH));
        settled_w = ~|dirty_q && state_q == IDLE && !tick_pend;
        for (int i = 0; i < N_CH; i++) if (cur_q[i] != target_q[i]) settled_w = 1'b0;
        rdata_d = '0;
        if (access && ch_ok) rdata_d = {24'b0, cur_q[ch], target_q[ch]};
        else if (access && addr[5:2] == REG_PERIOD) rdata_d = 32'(period_q);
        else if (access && addr[5:2] == REG_STATUS) rdata_d = {31'b0, settled_w};
        ready_d = access;
        state_d = state_q;
        idx_d = idx_q;
        step_en_d = step_en_q;
        target_d = target_q;
        cur_d = cur_q;
        dirty_d = dirty_q;
        period_d = period_q;
        m_valid_d = m_valid_q;
        m_wstrb_d = m_wstrb_q;
        m_addr_d = m_addr_q;
        m_wdata_d = m_wdata_q;
        tick_clr = 1'b0;
        c = cur_q[idx_q];
        t = target_q[idx_q];
        step = step_en_q && c != t;
        nv = !step ? c : (c < t ? c + 1'b1 : c - 1'b1);
        need = step || dirty_q[idx_q];
        case (state_q)
            IDLE: if (tick_pend || |dirty_q) begin
                step_en_d = tick_pend;
                tick_clr = 1'b1;
                idx_d = '0;
                state_d = SCAN;
            end
            SCAN: if (need) begin
                cur_d[idx_q] = nv;
                dirty_d[idx_q] = 1'b0;
                m_addr_d = MIX_BASE + {27'b0, idx_q, 2'b00};
                m_wdata_d = {{(32-VOL_W){1'b0}}, nv};
                m_wstrb_d = 4'b0001;
                m_valid_d = 1'b1;
                state_d = WRITE;
            end else state_d = NEXT;
            WRITE: if (m_ready) begin
                m_valid_d = 1'b0;
                m_wstrb_d = 4'b0000;
                state_d = NEXT;
            end
            NEXT: begin
                state_d = (idx_q == 3'(N_CH - 1)) ? IDLE : SCAN;
                idx_d = (idx_q == 3'(N_CH - 1)) ? idx_q : idx_q + 1'b1;
            end
        endcase
        // CPU writes land after the sweep update so an immediate jump overrides a same-cycle step
        if (wr && ch_ok) begin
            target_d[ch] = wdata[VOL_W-1:0];
            if (wdata[IMM_BIT]) begin
                cur_d[ch] = wdata[VOL_W-1:0];
                dirty_d[ch] = 1'b1;
            end
        end
        tick_reload = wr && addr[5:2] == REG_PERIOD;
        if (tick_reload) period_d = wdata[DIV_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q <= '0;
            step_en_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                target_q[i] <= '0;
                cur_q[i] <= '0;
            end
            dirty_q <= '1;
            period_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            m_valid_q <= 1'b0;
            m_wstrb_q <= '0;
            m_addr_q <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            step_en_q <= step_en_d;
            target_q <= target_d;
            cur_q <= cur_d;
            dirty_q <= dirty_d;
            period_q <= period_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            m_valid_q <= m_valid_d;
            m_wstrb_q <= m_wstrb_d;
            m_addr_q <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign m_valid = m_valid_q;
    assign m_wstrb = m_wstrb_q;
    assign m_addr = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign settled = settled_w;
endmodule

// File: tb/tb_mixer_fader.sv
// tb_mixer_fader: directed fades checked against a per-channel volume model and a mixer-write log
module tb_mixer_fader;
    localparam int N_CH = 8;
    logic clk = 1'b0, reset = 1'b1, valid = 1'b0, hold = 1'b0, mv_d = 1'b0;
    logic ready, m_valid, m_ready, settled;
    logic [3:0] wstrb = 4'b0, m_wstrb;
    logic [31:0] addr = '0, wdata = '0, rdata, m_addr, m_wdata;
    int vectors = 0, errors = 0, cyc = 0;
    int m_tgt [N_CH], m_cur [N_CH], jump_val [N_CH];
    bit jump_pend [N_CH];
    int log_addr [$], log_data [$], log_time [$];
    bit pv = 0;
    logic [31:0] pa, pd, rd;

    mixer_fader #(.N_CH(N_CH), .DIV_W(16), .MIX_BASE(32'h0)) dut (
        .clk(clk), .reset(reset), .valid(valid), .ready(ready), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .rdata(rdata), .m_valid(m_valid), .m_ready(m_ready),
        .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata), .settled(settled)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        mv_d <= m_valid;
    end
    assign m_ready = mv_d & ~hold;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_tgt[i] = 0; m_cur[i] = 0; jump_val[i] = 0; jump_pend[i] = 1;
        end
        log_addr.delete(); log_data.delete(); log_time.delete();
    endtask

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_time.delete();
    endtask

    // A mixer write must carry a pending jump value, or one step of the last volume toward its target
    task automatic model_write(logic [31:0] a, logic [31:0] d);
        int ch, e;
        log_addr.push_back(int'(a)); log_data.push_back(int'(d)); log_time.push_back(cyc);
        check("m_addr_range", {31'b0, a < 32'(4 * N_CH) && a[1:0] == 2'b00}, 32'd1);
        if (a >= 32'(4 * N_CH)) return;
        ch = int'(a[4:2]);
        if (jump_pend[ch]) begin
            e = jump_val[ch]; jump_pend[ch] = 0;
        end else if (m_cur[ch] != m_tgt[ch]) e = m_cur[ch] < m_tgt[ch] ? m_cur[ch] + 1 : m_cur[ch] - 1;
        else e = -1;
        check("m_wdata_model", d, 32'(e));
        if (e >= 0) m_cur[ch] = e;
    endtask

    always @(negedge clk) begin
        if (reset) pv = 0;
        else begin
            check("m_wstrb", {28'b0, m_wstrb}, m_valid ? 32'd1 : 32'd0);
            if (pv) begin
                check("stall_valid", {31'b0, m_valid}, 32'd1);
                check("stall_addr", m_addr, pa);
                check("stall_data", m_wdata, pd);
            end
            pv = m_valid && !m_ready; pa = m_addr; pd = m_wdata;
            if (m_valid && m_ready) model_write(m_addr, m_wdata);
        end
    end

    task automatic cpu_write(logic [31:0] a, logic [31:0] d);
        @(negedge clk); valid = 1; addr = a; wdata = d; wstrb = 4'b0001;
        @(posedge clk);
        if (a[5] == 1'b0) begin
            m_tgt[a[4:2]] = int'(d[3:0]);
            if (d[8]) begin
                m_cur[a[4:2]] = int'(d[3:0]); jump_val[a[4:2]] = int'(d[3:0]); jump_pend[a[4:2]] = 1;
            end
        end
        @(negedge clk); valid = 0; wstrb = 4'b0;
    endtask

    task automatic cpu_read(logic [31:0] a, output logic [31:0] d);
        @(negedge clk); valid = 1; addr = a; wstrb = 4'b0;
        @(posedge clk); @(negedge clk);
        check("ready_pulse", {31'b0, ready}, 32'd1);
        d = rdata; valid = 0;
    endtask

    task automatic wait_settled(string name, int budget);
        int n = 0;
        @(negedge clk);
        while (!settled && n < budget) begin @(negedge clk); n++; end
        check({name, "_settled"}, {31'b0, settled}, 32'd1);
    endtask

    task automatic wait_log(string name, int cnt, int budget);
        int n = 0;
        while (log_addr.size() < cnt && n < budget) begin @(negedge clk); n++; end
        check({name, "_count"}, 32'(log_addr.size()), 32'(cnt));
    endtask

    task automatic wait_mvalid(string name);
        int n = 0;
        while (!m_valid && n < 60) begin @(negedge clk); n++; end
        check({name, "_mvalid"}, {31'b0, m_valid}, 32'd1);
    endtask

    task automatic check_reset_sweep(string name);
        check({name, "_writes"}, 32'(log_addr.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            check({name, "_addr"}, 32'(log_addr[i]), 32'(4 * i));
            check({name, "_data"}, 32'(log_data[i]), 32'd0);
        end
    endtask

    initial begin
        int exp5 [$];
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_m_wstrb", {28'b0, m_wstrb}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_settled", {31'b0, settled}, 32'd0);
        reset = 0;
        wait_settled("t1", 200);
        check_reset_sweep("t1");
        clear_log();

        cpu_write(32'h08, 32'h3);
        cpu_write(32'h20, 32'd4);
        wait_log("t2", 3, 400);
        cpu_write(32'h20, 32'd0);
        wait_settled("t2", 200);
        check("t2_writes", 32'(log_addr.size()), 32'd3);
        for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
            check("t2_addr", 32'(log_addr[i]), 32'h08);
            check("t2_data", 32'(log_data[i]), 32'(i + 1));
            if (i > 0) check("t2_gap_ok", {31'b0, (log_time[i] - log_time[i-1]) inside {[4:40]}}, 32'd1);
        end
        cpu_read(32'h24, rd); check("t2_status", rd, 32'd1);
        cpu_read(32'h08, rd); check("t2_readback", rd, 32'h33);
        clear_log();

        cpu_write(32'h14, 32'h109);
        wait_settled("t3", 200);
        repeat (50) @(negedge clk);
        check("t3_writes", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() > 0) begin
            check("t3_addr", 32'(log_addr[0]), 32'h14);
            check("t3_data", 32'(log_data[0]), 32'd9);
        end
        cpu_read(32'h14, rd); check("t3_readback", rd, 32'h99);
        cpu_read(32'h28, rd); check("t3_unmapped", rd, 32'd0);
        cpu_read(32'h20, rd); check("t3_period", rd, 32'd0);
        clear_log();

        hold = 1;
        cpu_write(32'h10, 32'h7);
        cpu_write(32'h0C, 32'h105);
        wait_mvalid("t4");
        cpu_write(32'h20, 32'd3);
        repeat (10) begin @(negedge clk); check("t4_hold", {31'b0, m_valid}, 32'd1); end
        cpu_write(32'h20, 32'd0);
        repeat (6) begin @(negedge clk); check("t4_hold", {31'b0, m_valid}, 32'd1); end
        hold = 0;
        repeat (100) @(negedge clk);
        check("t4_writes", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() > 1) begin
            check("t4_addr1", 32'(log_addr[1]), 32'h10);
            check("t4_data1", 32'(log_data[1]), 32'd1);
        end
        cpu_write(32'h10, 32'h1);
        wait_settled("t4", 100);
        clear_log();

        cpu_write(32'h00, 32'h108);
        cpu_write(32'h00, 32'h2);
        wait_log("t5_jump", 1, 100);
        cpu_write(32'h20, 32'd1);
        wait_log("t5_down", 7, 400);
        cpu_write(32'h00, 32'h8);
        wait_log("t5_rev", 9, 200);
        cpu_write(32'h00, 32'h2);
        wait_log("t5_back", 11, 200);
        cpu_write(32'h20, 32'd0);
        wait_settled("t5", 200);
        exp5 = '{8, 7, 6, 5, 4, 3, 2, 3, 4, 3, 2};
        check("t5_writes", 32'(log_addr.size()), 32'd11);
        for (int i = 0; i < 11 && i < log_addr.size(); i++) begin
            check("t5_addr", 32'(log_addr[i]), 32'h0);
            check("t5_data", 32'(log_data[i]), 32'(exp5[i]));
        end
        cpu_read(32'h00, rd); check("t5_readback", rd, 32'h22);

        hold = 1;
        cpu_write(32'h04, 32'h103);
        wait_mvalid("t6");
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        check("t6_m_valid", {31'b0, m_valid}, 32'd0);
        check("t6_m_wstrb", {28'b0, m_wstrb}, 32'd0);
        check("t6_m_addr", m_addr, 32'd0);
        check("t6_m_wdata", m_wdata, 32'd0);
        model_reset();
        hold = 0;
        @(negedge clk); reset = 0;
        wait_settled("t6", 200);
        check_reset_sweep("t6");
        cpu_read(32'h04, rd); check("t6_readback", rd, 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end
endmodule

// File: doc/mixer_fader.md
Name: mixer_fader

Overview:
- Volume-ramp scheduler in front of the 8-channel mixer's register port.
- The CPU programs per-channel target volumes and a step period through a slave bus.
- The block steps each channel's current volume by ±1 toward its target once per period.
- It pushes each changed volume to the mixer with a bus-master write, giving click-free fades without CPU involvement.

Parameters:
- N_CH, 8, number of channels managed (1..8).
- DIV_W, 16, width of the step-period counter.
- MIX_BASE, 32'h0000_0000, mixer base address; channel i is written at MIX_BASE + 4*i.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- valid  in  1  CPU slave request
- ready  out  1  CPU slave acknowledge
- wstrb  in  4  CPU byte strobes; only wstrb[0] is used
- addr  in  32  CPU address; addr[5:2] is decoded
- wdata  in  32  CPU write data
- rdata  out  32  CPU read data
- m_valid  out  1  mixer-bus request
- m_ready  in  1  mixer-bus acknowledge
- m_wstrb  out  4  mixer-bus strobes; 4'b0001 during writes, 0 otherwise
- m_addr  out  32  mixer-bus address
- m_wdata  out  32  mixer-bus data; {28'b0, vol}
- settled  out  1  high when current==target for all channels and no write is pending

Behaviour:
- Reset values:
  - ready=0, rdata=0, m_valid=0, m_wstrb=0, m_addr=0, m_wdata=0.
  - target[i]=0, cur[i]=0, period=0, tick counter=0, tick_pend=0.
  - dirty[i]=1 for all i, so the first sweep writes 0 to every mixer channel.
  - settled=0 until that sweep completes.
- Slave port:
  - ready <= valid & ~ready, a one-cycle pulse one clock after valid.
  - The access is performed on the cycle where valid & ~ready.
  - Writes take effect only if wstrb[0]=1.
- Register map:
  - addr[5]=0, ch = addr[4:2]; write: target[ch] <= wdata[3:0]; if wdata[8], cur[ch] <= wdata[3:0] and dirty[ch] <= 1 (immediate jump).
  - Channel read: rdata = {24'b0, cur[ch], target[ch]}.
  - Accesses with ch >= N_CH: writes ignored, reads return 0.
  - addr[5:2]=4'b1000: period[DIV_W-1:0], read/write.
  - addr[5:2]=4'b1001: status, read-only; rdata[0] = settled.
  - Any other address reads 0.
- Tick generation:
  - period==0 pauses ramping; the counter is held at 0 and no ticks are generated.
  - Otherwise the counter counts 0..period-1, and tick_pend is set when it wraps.
  - Writing period reloads the counter to 0.
  - tick_pend saturates at 1; extra ticks during a sweep are dropped.
- FSM states:
  - IDLE: if tick_pend or |dirty, latch step_en = tick_pend, clear tick_pend, set idx=0, go to SCAN.
  - SCAN (1 cycle per channel):
    - If step_en and cur[idx]!=target[idx], cur[idx] moves ±1 toward target and the channel needs a write.
    - If dirty[idx], the channel needs a write.
    - If a write is needed: load m_addr = MIX_BASE + 4*idx, m_wdata = new cur, m_wstrb=1, m_valid=1, clear dirty[idx], go to WRITE.
    - Otherwise go to NEXT.
  - WRITE: hold m_valid and all m_* outputs stable until m_ready=1; on that cycle drop m_valid/m_wstrb and go to NEXT. There is no timeout.
  - NEXT: if idx==N_CH-1, go to IDLE; else idx+1 and go to SCAN.
- Ramp rate is one volume step per channel per tick; a full 0→15 fade takes 15 ticks.
- Simultaneous events:
  - A CPU target write in the same cycle a channel is stepped: the new target is stored, and the step uses the old target.
  - A CPU immediate write in the same cycle a channel is stepped: the CPU value wins for cur, and dirty is set again.
  - A CPU write to a channel already scanned in this sweep is handled on the next sweep.
- Reset mid-WRITE: all outputs return to reset values on the next edge; m_valid drops with no completion.
- settled = (cur==target for all ch) & ~|dirty & (state==IDLE) & ~tick_pend.

Decomposition:
- Shared package holds:
  - Register offsets: REG_CH = 0..7, REG_PERIOD = 8, REG_STATUS = 9.
  - FSM state encoding: IDLE, SCAN, WRITE, NEXT.
  - Immediate-bit index: IMM_BIT = 8.
  - Volume width: VOL_W = 4.
- One natural sub-module, fader_tick: period counter with reload, pause and saturating pending flag.

Test Plan:
- Reset release, m_ready tied to m_valid delayed by 1 → 8 writes to addrs 0x00..0x1C with data 0, then settled=1.
- period=4, target[2]=3, cur=0 → exactly 3 writes to 0x08 with data 1, 2, 3, spaced 4 clk apart (±sweep length); settled=1 afterwards.
- target[5]=9 with wdata[8]=1, period=0 → single write 0x14 ← 9; no further writes; readback of ch5 returns 0x99.
- m_ready held low 20 cycles during a write → m_valid and m_addr/m_wdata stable for all 20 cycles; a tick in that window sets only one pending sweep.
- cur[0]=8, target[0]=2, period=1 → writes 7, 6, 5, 4, 3, 2 on successive sweeps; target rewritten to 8 mid-ramp → ramp reverses on the next step.
- reset asserted while in WRITE → next cycle m_valid=0, m_wstrb=0; after release, all 8 channels are rewritten with 0.
